// File: rtl/pc_interface_initiator.sv
// Byte-serial bank access initiator: frames a header (plus write data) into a UART TX FIFO and collects an ack or read data from an RX FIFO.
// o_done pulses one cycle after the final RX pop or timeout; TX stalls byte-for-byte while i_tx_rdy is low.
module pc_interface_initiator #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 3,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_req_wr,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err,
    output logic [1:0]            o_err_code,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_wr,
    input  logic                  i_tx_rdy,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_rd
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BCNT_W     = $clog2(DATA_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_HDR  = 3'd1,
        TX_DATA = 3'd2,
        RX_ACK  = 3'd3,
        RX_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift_nxt;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [BCNT_W-1:0]       bcnt;
    logic [TIMEOUT_WIDTH-1:0] tcnt;
    logic [TIMEOUT_WIDTH-1:0] tcnt_inc;
    logic                    err_q;
    logic [1:0]              err_code_q;
    logic                    last_byte;
    logic                    timeout_hit;
    logic [5:0]              addr6;
    logic [7:0]              hdr_byte;
    logic                    tx_wr;
    logic [7:0]              tx_byte;
    logic                    rx_rd;

    assign tcnt_inc     = tcnt + TIMEOUT_WIDTH'(1);
    assign timeout_hit  = (tcnt_inc == '1);
    assign last_byte    = (bcnt == BCNT_W'(DATA_BYTES - 1));
    assign rx_shift_nxt = DATA_WIDTH'({rx_shift, i_rx_data});

    always_comb begin
        addr6                   = '0;
        addr6[ADDR_WIDTH-1:0]   = addr_q;
    end
    assign hdr_byte = {wr_q, 1'b0, addr6};

    always_comb begin
        state_nxt = state;
        tx_wr     = 1'b0;
        tx_byte   = 8'h00;
        rx_rd     = 1'b0;
        case (state)
            IDLE: begin
                // Anything still in the RX FIFO here is stale and gets discarded.
                rx_rd = i_rx_valid;
                if (i_req) state_nxt = TX_HDR;
            end
            TX_HDR: begin
                tx_byte = hdr_byte;
                tx_wr   = i_tx_rdy;
                if (i_tx_rdy) state_nxt = wr_q ? TX_DATA : RX_DATA;
            end
            TX_DATA: begin
                tx_byte = data_q[DATA_WIDTH-1 -: 8];
                tx_wr   = i_tx_rdy;
                if (i_tx_rdy && last_byte) state_nxt = RX_ACK;
            end
            RX_ACK, RX_DATA: begin
                rx_rd = i_rx_valid;
                if (i_rx_valid) begin
                    if (state == RX_ACK || last_byte) state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_rst) begin
            state_nxt = IDLE;
            tx_wr     = 1'b0;
            tx_byte   = 8'h00;
            rx_rd     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rx_shift   <= '0;
            rd_data_q  <= '0;
            bcnt       <= '0;
            tcnt       <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        wr_q       <= i_req_wr;
                        addr_q     <= i_req_addr;
                        data_q     <= i_req_data;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        bcnt       <= '0;
                        tcnt       <= '0;
                    end
                end
                TX_HDR: begin
                    if (i_tx_rdy) begin
                        bcnt <= '0;
                        tcnt <= '0;
                    end
                end
                TX_DATA: begin
                    if (i_tx_rdy) begin
                        data_q <= data_q << 8;
                        bcnt   <= last_byte ? '0 : bcnt + BCNT_W'(1);
                        tcnt   <= '0;
                    end
                end
                RX_ACK: begin
                    if (i_rx_valid) begin
                        tcnt <= '0;
                        if (i_rx_data != 8'h06) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b10;
                        end
                    end else begin
                        tcnt <= tcnt_inc;
                        if (timeout_hit) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end
                    end
                end
                RX_DATA: begin
                    if (i_rx_valid) begin
                        tcnt     <= '0;
                        rx_shift <= rx_shift_nxt;
                        bcnt     <= last_byte ? '0 : bcnt + BCNT_W'(1);
                        if (last_byte) rd_data_q <= rx_shift_nxt;
                    end else begin
                        tcnt <= tcnt_inc;
                        if (timeout_hit) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end
                    end
                end
                DONE: begin
                    bcnt <= '0;
                    tcnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Reset blanks every output immediately, not just after the edge.
    assign o_busy     = ~i_rst & (state inside {TX_HDR, TX_DATA, RX_ACK, RX_DATA});
    assign o_done     = ~i_rst & (state == DONE);
    assign o_err      = ~i_rst & err_q;
    assign o_err_code = i_rst ? 2'b00 : err_code_q;
    assign o_rd_data  = i_rst ? '0 : rd_data_q;
    assign o_tx_wr    = tx_wr;
    assign o_tx_data  = tx_byte;
    assign o_rx_rd    = rx_rd;

endmodule

// File: tb/tb_pc_interface_initiator.sv
// Bench for pc_interface_initiator: queue-based TX/RX FIFO models and a transaction-level reference for bytes, errors and read data.
module tb_pc_interface_initiator;

    logic        clk = 1'b0;
    logic        rst, req, req_wr, tx_rdy, rx_valid;
    logic [2:0]  req_addr;
    logic [15:0] req_data;
    logic [7:0]  rx_data;
    logic        busy, done, err, tx_wr, rx_rd;
    logic [1:0]  err_code;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;

    int checks = 0;
    int passed = 0;

    logic [7:0] rxq[$];
    logic [7:0] txlog[$];
    logic [7:0] resp_q[$];
    int cyc = 0, rdy_mode = 0, resp_after = 1, resp_wait = 0;
    int bad_tx, bad_rx, done_cnt, done_cyc, last_pop_cyc, hdr_cyc;
    logic [15:0] model_rd = 16'h0;

    pc_interface_initiator #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .TIMEOUT_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_wr(req_wr), .i_req_addr(req_addr),
        .i_req_data(req_data), .o_busy(busy), .o_done(done), .o_rd_data(rd_data),
        .o_err(err), .o_err_code(err_code), .o_tx_data(tx_data), .o_tx_wr(tx_wr),
        .i_tx_rdy(tx_rdy), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_rd(rx_rd)
    );

    always #5 clk = ~clk;

    task automatic refresh_rx();
        rx_valid = (rxq.size() > 0);
        rx_data  = rx_valid ? rxq[0] : 8'h00;
    endtask

    // One clock: sample outputs at negedge, apply FIFO effects and new inputs after the edge.
    task automatic tick();
        logic w, r;
        logic [7:0] b;
        @(negedge clk);
        w = tx_wr; r = rx_rd; b = tx_data;
        if (w && !tx_rdy) bad_tx++;
        if (r && !rx_valid) bad_rx++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (r) last_pop_cyc = cyc;
        if (w && txlog.size() == 0) hdr_cyc = cyc;
        @(posedge clk); #1;
        if (w) txlog.push_back(b);
        if (r && rxq.size() > 0) void'(rxq.pop_front());
        if (resp_q.size() > 0 && txlog.size() >= resp_after) begin
            if (resp_wait > 0) resp_wait--;
            else begin
                rxq.push_back(resp_q.pop_front());
                resp_wait = $urandom_range(0, 2);
            end
        end
        refresh_rx();
        case (rdy_mode)
            0:       tx_rdy = 1'b1;
            1:       tx_rdy = ~tx_rdy;
            3:       tx_rdy = 1'b0;
            default: tx_rdy = 1'($urandom_range(0, 1));
        endcase
        req = 1'b0;
        cyc++;
    endtask

    // Issues one request and runs until o_done (bounded); inject_at >= 0 fires a second, illegal request mid-flight.
    task automatic run_txn(input logic wr, input logic [2:0] a, input logic [15:0] d,
                           input int mode, input int inject_at, output bit finished);
        txlog.delete();
        done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; hdr_cyc = -1; bad_tx = 0; bad_rx = 0;
        rdy_mode = mode; resp_after = wr ? 3 : 1; resp_wait = $urandom_range(0, 3);
        tx_rdy = (mode == 3) ? 1'b0 : 1'b1;
        req = 1'b1; req_wr = wr; req_addr = a; req_data = d;
        tick();
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            if (i == inject_at) begin
                req = 1'b1; req_wr = ~wr; req_addr = ~a; req_data = ~d;
            end
            tick();
        end
        finished = (done_cnt > 0);
        tick();
        tick();
    endtask

    function automatic logic [31:0] txlog_packed();
        logic [31:0] v = 32'h0;
        foreach (txlog[i]) v = (v << 8) | 32'(txlog[i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_tx(input logic wr, input logic [2:0] a, input logic [15:0] d);
        logic [7:0] hdr = (wr ? 8'h80 : 8'h00) + 8'(a);
        return wr ? {8'h00, hdr, d} : {24'h0, hdr};
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = 0; req_wr = 0; req_addr = 0; req_data = 0; tx_rdy = 1; rxq.delete(); refresh_rx();
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if ({busy, done, err, err_code, tx_wr, rx_rd, tx_data, rd_data} !== 30'h0)
            $display("FAIL reset_outputs got busy=%b done=%b err=%b code=%b txwr=%b rxrd=%b txd=%h rd=%h want all 0",
                     busy, done, err, err_code, tx_wr, rx_rd, tx_data, rd_data);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rd = 16'h0;
        tick();
        checks++;
        if (busy !== 1'b0 || txlog.size() != 0) $display("FAIL reset_idle got busy=%b txbytes=%0d want 0/0", busy, txlog.size());
        else passed++;
    endtask

    task automatic test_write_basic();
        bit ok;
        resp_q = '{8'h06};
        run_txn(1'b1, 3'd5, 16'hBEEF, 0, -1, ok);
        checks++;
        if (!ok || txlog.size() != 3 || txlog_packed() !== 32'h0085BEEF)
            $display("FAIL write_bytes got n=%0d bytes=%h done=%b want 3 0085beef", txlog.size(), txlog_packed(), ok);
        else passed++;
        checks++;
        if (err !== 1'b0 || err_code !== 2'b00 || done_cnt != 1)
            $display("FAIL write_status got err=%b code=%b dones=%0d want 0 00 1", err, err_code, done_cnt);
        else passed++;
    endtask

    task automatic test_read_basic();
        bit ok;
        resp_q = '{8'h12, 8'h34};
        run_txn(1'b0, 3'd2, 16'h0000, 0, -1, ok);
        model_rd = 16'h1234;
        checks++;
        if (!ok || txlog.size() != 1 || txlog_packed() !== 32'h02)
            $display("FAIL read_hdr got n=%0d bytes=%h want 1 02", txlog.size(), txlog_packed());
        else passed++;
        checks++;
        if (rd_data !== model_rd || err !== 1'b0) $display("FAIL read_data got %h err=%b want %h 0", rd_data, err, model_rd);
        else passed++;
        checks++;
        if (done_cyc != last_pop_cyc + 1) $display("FAIL read_latency got done@%0d pop@%0d want pop+1", done_cyc, last_pop_cyc);
        else passed++;
    endtask

    task automatic test_tx_backpressure();
        bit ok;
        logic [15:0] d;
        for (int m = 1; m <= 2; m++) begin
            d = 16'($urandom);
            resp_q = '{8'h06};
            run_txn(1'b1, 3'd3, d, m, -1, ok);
            checks++;
            if (!ok || txlog.size() != 3 || bad_tx != 0 || txlog_packed() !== exp_tx(1'b1, 3'd3, d))
                $display("FAIL tx_backpressure mode=%0d got n=%0d bytes=%h stalled_pushes=%0d want 3 %h 0",
                         m, txlog.size(), txlog_packed(), bad_tx, exp_tx(1'b1, 3'd3, d));
            else passed++;
        end
    endtask

    task automatic test_nack();
        bit ok;
        resp_q = '{8'h15};
        run_txn(1'b1, 3'd1, 16'hA55A, 0, -1, ok);
        checks++;
        if (!ok || err !== 1'b1 || err_code !== 2'b10 || done_cnt != 1)
            $display("FAIL nack got err=%b code=%b dones=%0d want 1 10 1", err, err_code, done_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        bit ok;
        resp_q.delete();
        run_txn(1'b0, 3'd4, 16'h0, 0, -1, ok);
        checks++;
        if (!ok || err !== 1'b1 || err_code !== 2'b01)
            $display("FAIL timeout_err got err=%b code=%b done=%b want 1 01 1", err, err_code, ok);
        else passed++;
        checks++;
        if (rd_data !== model_rd) $display("FAIL timeout_rd_hold got %h want %h", rd_data, model_rd);
        else passed++;
        checks++;
        if (done_cyc - hdr_cyc != 16) $display("FAIL timeout_cycles got %0d want 16 (15 idle + done)", done_cyc - hdr_cyc);
        else passed++;
    endtask

    task automatic test_stale_drain();
        bit ok;
        logic [15:0] v;
        v = 16'($urandom);
        rxq.push_back(8'hEE);
        refresh_rx();
        resp_q = '{v[15:8], v[7:0]};
        run_txn(1'b0, 3'd6, 16'h0, 0, -1, ok);
        model_rd = v;
        checks++;
        if (!ok || rd_data !== model_rd || rxq.size() != 0 || bad_rx != 0)
            $display("FAIL stale_drain got rd=%h left=%0d badpops=%0d want %h 0 0", rd_data, rxq.size(), bad_rx, model_rd);
        else passed++;
    endtask

    task automatic test_random();
        bit ok;
        logic wr;
        logic [2:0] a;
        logic [15:0] d, v;
        logic [7:0] ack;
        logic [1:0] exp_code;
        int fails = 0;
        for (int n = 0; n < 20; n++) begin
            wr = 1'($urandom_range(0, 1)); a = 3'($urandom); d = 16'($urandom); v = 16'($urandom);
            ack = ($urandom_range(0, 1) == 1) ? 8'h06 : 8'($urandom);
            if (wr) resp_q = '{ack}; else resp_q = '{v[15:8], v[7:0]};
            run_txn(wr, a, d, $urandom_range(0, 2), -1, ok);
            exp_code = (wr && ack != 8'h06) ? 2'b10 : 2'b00;
            if (!wr) model_rd = v;
            checks++;
            if (!ok || txlog.size() != (wr ? 3 : 1) || txlog_packed() !== exp_tx(wr, a, d) || bad_tx != 0 || bad_rx != 0) begin
                $display("FAIL rand_tx #%0d got n=%0d bytes=%h want %h", n, txlog.size(), txlog_packed(), exp_tx(wr, a, d));
                fails++;
            end else passed++;
            checks++;
            if (err_code !== exp_code || err !== (exp_code != 2'b00) || rd_data !== model_rd || done_cnt != 1) begin
                $display("FAIL rand_status #%0d got code=%b err=%b rd=%h dones=%0d want %b %h 1",
                         n, err_code, err, rd_data, done_cnt, exp_code, model_rd);
                fails++;
            end else passed++;
        end
    endtask

    task automatic test_reset_mid_and_ignore();
        bit ok;
        txlog.delete(); rdy_mode = 0; tx_rdy = 1'b1; bad_tx = 0; done_cnt = 0; resp_q.delete();
        req = 1'b1; req_wr = 1'b1; req_addr = 3'd7; req_data = 16'h1357;
        tick();
        tick();
        rdy_mode = 3; tx_rdy = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || txlog.size() != 1) $display("FAIL mid_tx_state got busy=%b n=%0d want 1 1", busy, txlog.size());
        else passed++;
        rst = 1'b1; tx_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, err_code, tx_wr, rx_rd, tx_data, rd_data} !== 30'h0)
            $display("FAIL rst_during got busy=%b txwr=%b txd=%h rd=%h want 0", busy, tx_wr, tx_data, rd_data);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rd = 16'h0;
        @(negedge clk);
        checks++;
        if ({busy, done, err, err_code, tx_wr, rx_rd, tx_data, rd_data} !== 30'h0)
            $display("FAIL rst_after got busy=%b txwr=%b txd=%h rd=%h want 0", busy, tx_wr, tx_data, rd_data);
        else passed++;
        @(posedge clk); #1;
        rdy_mode = 0;
        repeat (10) tick();
        checks++;
        if (txlog.size() != 1 || done_cnt != 0) $display("FAIL rst_no_resume got n=%0d dones=%0d want 1 0", txlog.size(), done_cnt);
        else passed++;
        resp_q = '{8'hC3, 8'h3C};
        run_txn(1'b0, 3'd1, 16'h0, 0, 2, ok);
        model_rd = 16'hC33C;
        repeat (15) tick();
        checks++;
        if (!ok || txlog.size() != 1 || txlog_packed() !== 32'h01 || done_cnt != 1 || rd_data !== model_rd || busy !== 1'b0)
            $display("FAIL busy_ignore got n=%0d bytes=%h dones=%0d rd=%h busy=%b want 1 01 1 %h 0",
                     txlog.size(), txlog_packed(), done_cnt, rd_data, busy, model_rd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_tx_backpressure();
        test_nack();
        test_timeout();
        test_stale_drain();
        test_random();
        test_reset_mid_and_ignore();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
